shift_arbiter: RTL and testbench

Issue controller that shares one pipelined 32-bit barrel shifter between two requesters, A and B.
- Arbitrates round-robin and drives the shifter's operand/amount/direction inputs one operation per cycle.
- Tracks each operation's owner through the shifter's fixed pipeline latency and routes the result back to the correct requester.
- Sits between the two client datapaths and the shifter instance.
- Provides a drain control and an idle indication for quiescing the shifter.

---
 rtl/shift_arbiter.sv | 153 +++++++++++++++
 tb/tb_shift_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_arbiter.sv
// Round-robin issue controller sharing one pipelined barrel shifter
// between requesters A and B, with owner tracking and drain/idle.
//
// Ports:
//   clk, reset (async, active-low)
//   a_valid/a_ready/a_data/a_amt/a_dir : requester A
//   b_valid/b_ready/b_data/b_amt/b_dir : requester B
//   drain : 1 = accept no new requests
//   sh_valid/sh_data/sh_amt/sh_dir : issue to shifter
//   sh_result : shifter output, LAT cycles after sh_valid
//   a_resp_valid/b_resp_valid/resp_data : returned result
//   idle : nothing issued, in flight, or being returned
module shift_arbiter #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5,
  parameter int LAT   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] a_data,
  input  logic [AMT_W-1:0] a_amt,
  input  logic             a_dir,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic [AMT_W-1:0] b_amt,
  input  logic             b_dir,
  input  logic             drain,
  output logic             sh_valid,
  output logic [WIDTH-1:0] sh_data,
  output logic [AMT_W-1:0] sh_amt,
  output logic             sh_dir,
  input  logic [WIDTH-1:0] sh_result,
  output logic             a_resp_valid,
  output logic             b_resp_valid,
  output logic [WIDTH-1:0] resp_data,
  output logic             idle
);

  typedef struct packed {
    logic vld;
    logic own;
  } tag_t;

  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

  logic last_grant;
  logic sh_own;
  logic hs_a;
  logic hs_b;
  logic any_tag;
  tag_t tag_out;
  tag_t tag_q [LAT];

  // last_grant holds the previous winner; the
  // other side wins when both are valid.
  assign a_ready = ~drain & a_valid &
                   (~b_valid | (last_grant == OWN_B));
  assign b_ready = ~drain & b_valid &
                   (~a_valid | (last_grant == OWN_A));

  assign hs_a = a_valid & a_ready;
  assign hs_b = b_valid & b_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= OWN_B;
    end else if (hs_a) begin
      last_grant <= OWN_A;
    end else if (hs_b) begin
      last_grant <= OWN_B;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_valid <= 1'b0;
      sh_data  <= '0;
      sh_amt   <= '0;
      sh_dir   <= 1'b0;
      sh_own   <= OWN_A;
    end else begin
      sh_valid <= hs_a | hs_b;
      unique case (1'b1)
        hs_a: begin
          sh_data <= a_data;
          sh_amt  <= a_amt;
          sh_dir  <= a_dir;
          sh_own  <= OWN_A;
        end
        hs_b: begin
          sh_data <= b_data;
          sh_amt  <= b_amt;
          sh_dir  <= b_dir;
          sh_own  <= OWN_B;
        end
        default: begin
          sh_data <= sh_data;
          sh_amt  <= sh_amt;
          sh_dir  <= sh_dir;
          sh_own  <= sh_own;
        end
      endcase
    end
  end

  // Tag k is valid one cycle after sh_valid plus k,
  // so the last stage lines up with sh_result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= '{vld: sh_valid, own: sh_own};
      for (int i = 1; i < LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign tag_out = tag_q[LAT-1];

  always_comb begin
    any_tag = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      any_tag = any_tag | tag_q[i].vld;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_resp_valid <= 1'b0;
      b_resp_valid <= 1'b0;
      resp_data    <= '0;
    end else begin
      a_resp_valid <= tag_out.vld &
                      (tag_out.own == OWN_A);
      b_resp_valid <= tag_out.vld &
                      (tag_out.own == OWN_B);
      if (tag_out.vld) begin
        resp_data <= sh_result;
      end
    end
  end

  assign idle = ~sh_valid & ~any_tag &
                ~a_resp_valid & ~b_resp_valid;

endmodule

// File: tb/tb_shift_arbiter.sv
// Randomized self-checking bench for shift_arbiter with a
// behavioural shifter and a queue-based response model.
module tb_shift_arbiter;

  localparam int W   = 32;
  localparam int AW  = 5;
  localparam int LAT = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          a_valid, a_ready, a_dir;
  logic [W-1:0]  a_data;
  logic [AW-1:0] a_amt;
  logic          b_valid, b_ready, b_dir;
  logic [W-1:0]  b_data;
  logic [AW-1:0] b_amt;
  logic          drain;
  logic          sh_valid, sh_dir;
  logic [W-1:0]  sh_data, sh_result;
  logic [AW-1:0] sh_amt;
  logic          a_resp_valid, b_resp_valid, idle;
  logic [W-1:0]  resp_data;

  always #5 clk = ~clk;

  shift_arbiter #(.WIDTH(W), .AMT_W(AW), .LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready),
    .a_data(a_data), .a_amt(a_amt), .a_dir(a_dir),
    .b_valid(b_valid), .b_ready(b_ready),
    .b_data(b_data), .b_amt(b_amt), .b_dir(b_dir),
    .drain(drain),
    .sh_valid(sh_valid), .sh_data(sh_data),
    .sh_amt(sh_amt), .sh_dir(sh_dir),
    .sh_result(sh_result),
    .a_resp_valid(a_resp_valid),
    .b_resp_valid(b_resp_valid),
    .resp_data(resp_data), .idle(idle)
  );

  function automatic logic [W-1:0] shf(
    input logic [W-1:0] d,
    input logic [AW-1:0] n,
    input logic dir);
    return dir ? (d >> n) : (d << n);
  endfunction

  // Behavioural shifter: garbage when nothing was issued.
  logic [W-1:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= sh_valid ? shf(sh_data, sh_amt, sh_dir)
                        : W'($urandom);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign sh_result = pipe[LAT-1];

  typedef struct {
    int           due;
    bit           own;
    logic [W-1:0] res;
  } exp_t;

  exp_t          q[$];
  int            cyc;
  bit            last_b;
  logic [W-1:0]  m_resp, m_sd;
  logic [AW-1:0] m_sa;
  logic          m_sdir;
  int            n_chk = 0;
  int            n_pass = 0;

  task automatic chk(input string tag,
                     input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  task automatic model_clear();
    q.delete();
    last_b = 1'b1;
    m_resp = '0;
    m_sd   = '0;
    m_sa   = '0;
    m_sdir = 1'b0;
  endtask

  // Called just after a rising edge; drives inputs, checks
  // readies mid-cycle, then checks outputs after next edge.
  task automatic step(
    input bit av, input logic [W-1:0] ad,
    input logic [AW-1:0] aa, input bit adr,
    input bit bv, input logic [W-1:0] bd,
    input logic [AW-1:0] ba, input bit bdr,
    input bit dr);
    bit ea, eb, pulse;
    a_valid = av; a_data = ad; a_amt = aa; a_dir = adr;
    b_valid = bv; b_data = bd; b_amt = ba; b_dir = bdr;
    drain = dr;
    @(negedge clk);
    ea = !dr && av && (!bv || last_b);
    eb = !dr && bv && (!av || !last_b);
    chk("a_ready", a_ready, ea);
    chk("b_ready", b_ready, eb);
    @(posedge clk);
    #1;
    cyc++;
    if (ea || eb) begin
      last_b = eb;
      m_sd   = eb ? bd : ad;
      m_sa   = eb ? ba : aa;
      m_sdir = eb ? bdr : adr;
      q.push_back('{cyc + LAT + 1, eb,
                    shf(m_sd, m_sa, m_sdir)});
    end
    chk("sh_valid", sh_valid, ea || eb);
    chk("sh_data", sh_data, m_sd);
    chk("sh_amt", sh_amt, m_sa);
    chk("sh_dir", sh_dir, m_sdir);
    pulse = q.size() > 0 && q[0].due == cyc;
    if (pulse) begin
      chk("a_resp_valid", a_resp_valid, !q[0].own);
      chk("b_resp_valid", b_resp_valid, q[0].own);
      m_resp = q[0].res;
      void'(q.pop_front());
    end else begin
      chk("a_resp_idle", a_resp_valid, 0);
      chk("b_resp_idle", b_resp_valid, 0);
    end
    chk("resp_data", resp_data, m_resp);
    chk("idle", idle, q.size() == 0 && !pulse);
  endtask

  task automatic idle_steps(input int n, input bit dr);
    for (int i = 0; i < n; i++)
      step(0, W'($urandom), AW'($urandom), 0,
           0, W'($urandom), AW'($urandom), 0, dr);
  endtask

  task automatic both(input int n, input bit dr);
    for (int i = 0; i < n; i++)
      step(1, W'($urandom), AW'($urandom), 1'($urandom),
           1, W'($urandom), AW'($urandom), 1'($urandom), dr);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_sh_valid"}, sh_valid, 0);
    chk({tag, "_sh_data"}, sh_data, 0);
    chk({tag, "_a_resp"}, a_resp_valid, 0);
    chk({tag, "_b_resp"}, b_resp_valid, 0);
    chk({tag, "_resp_data"}, resp_data, 0);
    chk({tag, "_idle"}, idle, 1);
  endtask

  initial begin
    reset = 1'b0;
    drain = 1'b0;
    a_valid = 1; b_valid = 1;
    a_data = W'($urandom); a_amt = AW'($urandom); a_dir = 1;
    b_data = W'($urandom); b_amt = AW'($urandom); b_dir = 1;
    model_clear();
    cyc = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs("rst");
    chk("rst_a_ready", a_ready, 1);
    chk("rst_b_ready", b_ready, 0);
    @(negedge clk);
    a_valid = 0; b_valid = 0;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Contention right after reset: A,B,A,B,A,B.
    both(6, 0);
    idle_steps(LAT + 3, 0);

    // Single A request.
    step(1, 32'h8000_0001, 5'd4, 0,
         0, 0, 0, 0, 0);
    idle_steps(LAT + 1, 0);
    chk("single_resp_data", resp_data, 32'h0000_0010);
    chk("single_a_resp", a_resp_valid, 1);
    idle_steps(2, 0);

    // Fairness: B alone, then contention.
    for (int i = 0; i < 3; i++)
      step(0, 0, 0, 0,
           1, W'($urandom), AW'($urandom), 1'($urandom), 0);
    both(2, 0);
    idle_steps(LAT + 3, 0);

    // Drain with two in flight, then resume.
    both(2, 0);
    both(LAT + 4, 1);
    both(2, 0);
    idle_steps(LAT + 3, 0);

    // Reset while an A op is in flight.
    step(1, 32'h1234_5678, 5'd3, 1,
         0, 0, 0, 0, 0);
    idle_steps(2, 0);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_outs("mid");
    @(posedge clk);
    #1;
    chk_reset_outs("mid_hold");
    @(negedge clk);
    reset = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    idle_steps(LAT + 4, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, W'($urandom),
           AW'($urandom), 1'($urandom),
           $urandom_range(0, 3) != 0, W'($urandom),
           AW'($urandom), 1'($urandom),
           $urandom_range(0, 15) == 0);
    end
    idle_steps(LAT + 3, 0);
    chk("queue_empty", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
